// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight register writes, decodes the EX
// operand bypass selects one cycle ahead and raises the load-use stall.
module fwd_hazard_unit #(
  parameter int unsigned REG_W   = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [REG_W-1:0]         id_dst_addr,
  input  logic                     id_we,
  input  logic                     id_is_load,
  input  logic                     hold,
  input  logic                     flush,
  input  logic                     cnt_clr,
  output logic                     ld_stall,
  output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel,
  output logic [NUM_SRC-1:0]       ex_fwd_ld,
  output logic [CNT_W-1:0]         stall_cnt
);

  // Only T[0..DEPTH-1] are stored: the WB entry is never a forwarding source because the
  // register file is write-before-read.
  logic [DEPTH-1:0] t_wv_q, t_wv_d;
  logic [DEPTH-1:0] t_ld_q, t_ld_d;
  logic [REG_W-1:0] t_dst_q [DEPTH];
  logic [REG_W-1:0] t_dst_d [DEPTH];

  logic [DEPTH-1:0]   live;
  logic [DEPTH-1:0]   match [NUM_SRC];
  logic [NUM_SRC-1:0] load_hit;
  logic [SEL_W-1:0]   dec_sel [NUM_SRC];
  logic [NUM_SRC-1:0] dec_ld;
  logic [NUM_SRC-1:0] pend_q, pend_d;

  logic [NUM_SRC*SEL_W-1:0] sel_d;
  logic [NUM_SRC-1:0]       fld_d;
  logic [CNT_W-1:0]         cnt_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = t_wv_q[i] && (t_dst_q[i] != '0);
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        match[k][i] = id_src_used[k] && live[i] &&
                      (t_dst_q[i] == id_src_addr[k*REG_W +: REG_W]);
      end
      load_hit[k] = match[k][0] && t_ld_q[0];
    end
    ld_stall = id_valid && !flush && (|load_hit);
  end

  // Youngest producer wins: scan oldest to youngest so the smallest index overrides.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      dec_sel[k] = '0;
      dec_ld[k]  = 1'b0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (match[k][i]) begin
          dec_sel[k] = SEL_W'(i + 1);
          dec_ld[k]  = (i == 0) && t_ld_q[0];
        end
      end
      // A consumer that stalled on a load takes the load-return bypass once it issues.
      if (DEPTH > 1 && pend_q[k] && dec_sel[k] == SEL_W'(2)) begin
        dec_sel[k] = SEL_W'(1);
        dec_ld[k]  = 1'b1;
      end
    end
  end

  always_comb begin
    t_wv_d  = t_wv_q;
    t_ld_d  = t_ld_q;
    t_dst_d = t_dst_q;
    sel_d   = ex_fwd_sel;
    fld_d   = ex_fwd_ld;
    pend_d  = pend_q;
    if (!hold) begin
      for (int s = 1; s < DEPTH; s++) begin
        if (s == 1 && flush) begin
          t_wv_d[s]  = 1'b0;
          t_ld_d[s]  = 1'b0;
          t_dst_d[s] = '0;
        end else begin
          t_wv_d[s]  = t_wv_q[s-1];
          t_ld_d[s]  = t_ld_q[s-1];
          t_dst_d[s] = t_dst_q[s-1];
        end
      end
      if (flush || ld_stall) begin
        t_wv_d[0]  = 1'b0;
        t_ld_d[0]  = 1'b0;
        t_dst_d[0] = '0;
      end else begin
        t_wv_d[0]  = id_valid && id_we;
        t_ld_d[0]  = id_is_load;
        t_dst_d[0] = id_dst_addr;
      end
      if (flush || ld_stall || !id_valid) begin
        sel_d = '0;
        fld_d = '0;
      end else begin
        for (int k = 0; k < NUM_SRC; k++) begin
          sel_d[k*SEL_W +: SEL_W] = dec_sel[k];
          fld_d[k]                = dec_ld[k];
        end
      end
      pend_d = ld_stall ? load_hit : '0;
    end
  end

  always_comb begin
    cnt_d = stall_cnt;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (ld_stall && !hold && stall_cnt != '1) begin
      cnt_d = stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_wv_q     <= '0;
      t_ld_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        t_dst_q[i] <= '0;
      end
      pend_q     <= '0;
      ex_fwd_sel <= '0;
      ex_fwd_ld  <= '0;
      stall_cnt  <= '0;
    end else begin
      t_wv_q     <= t_wv_d;
      t_ld_q     <= t_ld_d;
      t_dst_q    <= t_dst_d;
      pend_q     <= pend_d;
      ex_fwd_sel <= sel_d;
      ex_fwd_ld  <= fld_d;
      stall_cnt  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: expected EX selects are queued when an ID
// instruction is driven and compared one cycle later.
module tb_fwd_hazard_unit;

  localparam int unsigned REG_W   = 4;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SEL_W   = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [REG_W-1:0]         id_dst_addr;
  logic                     id_we;
  logic                     id_is_load;
  logic                     hold;
  logic                     flush;
  logic                     cnt_clr;
  logic                     ld_stall;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;
  logic [NUM_SRC-1:0]       ex_fwd_ld;
  logic [CNT_W-1:0]         stall_cnt;

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] ld;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fwd_hazard_unit #(
    .REG_W  (REG_W),
    .NUM_SRC(NUM_SRC),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_src_addr(id_src_addr),
    .id_src_used(id_src_used),
    .id_dst_addr(id_dst_addr),
    .id_we      (id_we),
    .id_is_load (id_is_load),
    .hold       (hold),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .ld_stall   (ld_stall),
    .ex_fwd_sel (ex_fwd_sel),
    .ex_fwd_ld  (ex_fwd_ld),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] used, input logic [3:0] dst, input logic we,
                       input logic ld);
    id_valid    = v;
    id_src_addr = {s1, s0};
    id_src_used = used;
    id_dst_addr = dst;
    id_we       = we;
    id_is_load  = ld;
  endtask

  // Checks the zero-latency stall, then the registered selects after the edge.
  task automatic tick(input string tag, input logic exp_stall, input logic [3:0] exp_sel,
                      input logic [1:0] exp_ld);
    exp_t e;
    #1;
    chk({tag, "/ld_stall"}, 16'(ld_stall), 16'(exp_stall));
    sb.push_back({exp_sel, exp_ld});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "/sel"}, 16'(ex_fwd_sel), 16'(e.sel));
    chk({tag, "/fld"}, 16'(ex_fwd_ld), 16'(e.ld));
  endtask

  task automatic drain();
    instr(0, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("drain", 0, 4'b0000, 2'b00);
  endtask

  initial begin
    rst_n   = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    cnt_clr = 1'b0;
    instr(0, 0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("reset/sel", 16'(ex_fwd_sel), 16'h0);
    chk("reset/fld", 16'(ex_fwd_ld), 16'h0);
    chk("reset/cnt", 16'(stall_cnt), 16'h0);
    chk("reset/stall", 16'(ld_stall), 16'h0);
    rst_n = 1'b1;

    // ALU distance 1
    instr(1, 0, 0, 2'b00, 3, 1, 0); tick("alu1_prod", 0, 4'b0000, 2'b00);
    instr(1, 3, 5, 2'b11, 0, 0, 0); tick("alu1_cons", 0, 4'b0001, 2'b00);
    drain();

    // ALU distance 2 and 3 (WB is not forwarded)
    instr(1, 0, 0, 2'b00, 3, 1, 0); tick("alu2_prod", 0, 4'b0000, 2'b00);
    instr(0, 0, 0, 2'b00, 0, 0, 0); tick("alu2_gap", 0, 4'b0000, 2'b00);
    instr(1, 3, 0, 2'b01, 0, 0, 0); tick("alu2_cons", 0, 4'b0010, 2'b00);
    drain();
    instr(1, 0, 0, 2'b00, 3, 1, 0); tick("alu3_prod", 0, 4'b0000, 2'b00);
    instr(0, 0, 0, 2'b00, 0, 0, 0); tick("alu3_gap", 0, 4'b0000, 2'b00);
    tick("alu3_gap2", 0, 4'b0000, 2'b00);
    instr(1, 0, 3, 2'b10, 0, 0, 0); tick("alu3_cons", 0, 4'b0000, 2'b00);
    drain();

    // Load-use
    instr(1, 0, 0, 2'b00, 4, 1, 1); tick("lu_load", 0, 4'b0000, 2'b00);
    instr(1, 0, 4, 2'b10, 0, 0, 0); tick("lu_stall", 1, 4'b0000, 2'b00);
    tick("lu_issue", 0, 4'b0100, 2'b10);
    chk("lu_cnt", 16'(stall_cnt), 16'd1);
    drain();

    // Load at distance 2 needs no stall and forwards from WB stage 2
    instr(1, 0, 0, 2'b00, 4, 1, 1); tick("ld2_load", 0, 4'b0000, 2'b00);
    instr(0, 0, 0, 2'b00, 0, 0, 0); tick("ld2_gap", 0, 4'b0000, 2'b00);
    instr(1, 4, 0, 2'b01, 0, 0, 0); tick("ld2_cons", 0, 4'b0010, 2'b00);
    drain();

    // Youngest producer wins
    instr(1, 0, 0, 2'b00, 2, 1, 0); tick("young_old", 0, 4'b0000, 2'b00);
    instr(1, 0, 0, 2'b00, 2, 1, 0); tick("young_new", 0, 4'b0000, 2'b00);
    instr(1, 2, 2, 2'b11, 0, 0, 0); tick("young_cons", 0, 4'b0101, 2'b00);
    drain();

    // r0 destination and unused sources never match
    instr(1, 0, 0, 2'b00, 0, 1, 1); tick("r0_prod", 0, 4'b0000, 2'b00);
    instr(1, 0, 0, 2'b11, 0, 0, 0); tick("r0_cons", 0, 4'b0000, 2'b00);
    drain();
    instr(1, 0, 0, 2'b00, 7, 1, 1); tick("unused_prod", 0, 4'b0000, 2'b00);
    instr(1, 7, 7, 2'b00, 0, 0, 0); tick("unused_cons", 0, 4'b0000, 2'b00);
    drain();

    // Flush squashes the EX producer
    instr(1, 0, 0, 2'b00, 6, 1, 0); tick("fl_prod", 0, 4'b0000, 2'b00);
    instr(1, 6, 0, 2'b01, 0, 0, 0); flush = 1'b1; tick("fl_flush", 0, 4'b0000, 2'b00);
    flush = 1'b0; tick("fl_after", 0, 4'b0000, 2'b00);
    tick("fl_after2", 0, 4'b0000, 2'b00);
    drain();
    instr(1, 0, 0, 2'b00, 8, 1, 1); tick("fl_load", 0, 4'b0000, 2'b00);
    instr(1, 8, 0, 2'b01, 0, 0, 0); flush = 1'b1; tick("fl_nostall", 0, 4'b0000, 2'b00);
    flush = 1'b0; tick("fl_ld_after", 0, 4'b0000, 2'b00);
    drain();

    // Hold freezes registers and counter; stall still reflects inputs
    instr(1, 0, 0, 2'b00, 3, 1, 0); tick("hold_prod", 0, 4'b0000, 2'b00);
    instr(1, 3, 0, 2'b01, 9, 1, 1); tick("hold_cons", 0, 4'b0001, 2'b00);
    instr(1, 0, 9, 2'b10, 0, 0, 0); hold = 1'b1;
    for (int i = 0; i < 3; i++) tick("hold_frz", 1, 4'b0001, 2'b00);
    chk("hold_cnt", 16'(stall_cnt), 16'd1);
    hold = 1'b0; tick("hold_stall", 1, 4'b0000, 2'b00);
    tick("hold_issue", 0, 4'b0100, 2'b10);
    chk("hold_cnt2", 16'(stall_cnt), 16'd2);
    drain();

    // Clear acts under hold
    hold = 1'b1; cnt_clr = 1'b1; tick("clr_hold", 0, 4'b0000, 2'b00);
    chk("clr_cnt", 16'(stall_cnt), 16'd0);
    hold = 1'b0; cnt_clr = 1'b0;

    // Saturation: 2^CNT_W + 2 stall cycles
    instr(1, 4, 0, 2'b01, 4, 1, 1); tick("sat_first", 0, 4'b0000, 2'b00);
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      tick("sat_stall", 1, 4'b0000, 2'b00);
      tick("sat_issue", 0, 4'b0001, 2'b01);
    end
    chk("sat_cnt", 16'(stall_cnt), 16'hf);

    // Reset asserted while a stall is pending
    #1;
    chk("rst_mid_pre", 16'(ld_stall), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", 16'(ld_stall), 16'd0);
    chk("rst_mid_sel", 16'(ex_fwd_sel), 16'h0);
    chk("rst_mid_fld", 16'(ex_fwd_ld), 16'h0);
    chk("rst_mid_cnt", 16'(stall_cnt), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("rst_release", 0, 4'b0000, 2'b00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined core. It tracks in-flight register writes in an internal tag pipeline, decodes forwarding selects for the instruction in ID, and registers them so they are valid when that instruction reaches EX. It also generates the load-use stall, honours global hold and flush, and keeps a saturating load-stall counter. It is instantiated once in the core's control path, between the decode stage and the EX operand muxes.

## Interface
- REG_W, 4, register address width; address 0 is hardwired zero and is never tracked.
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 2, number of forwarding stages after EX (1 = MEM, ..., DEPTH = WB).
- CNT_W, 16, stall counter width.
- SEL_W, clog2(DEPTH+1), derived; width of one forwarding select.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  the ID instruction is real (not a bubble)
- id_src_addr  in  NUM_SRC*REG_W  source register addresses; source k is bits [k*REG_W +: REG_W]
- id_src_used  in  NUM_SRC  source k is actually read
- id_dst_addr  in  REG_W  destination register
- id_we  in  1  the instruction writes the register file
- id_is_load  in  1  the instruction is a load
- hold  in  1  global freeze; all pipeline registers hold
- flush  in  1  squash the ID and EX instructions
- cnt_clr  in  1  synchronous clear of stall_cnt
- ld_stall  out  1  combinational load-use stall request to ID/IF
- ex_fwd_sel  out  NUM_SRC*SEL_W  registered select per source: 0 = register file, s = forward from stage s
- ex_fwd_ld  out  NUM_SRC  registered; selects load data (not the ALU result) from MEM
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Tag pipeline entries are T[0..DEPTH], where T[0] is EX and T[s] is forwarding stage s. Each entry holds {wv, dst, ld}. An entry is live when wv=1 and dst!=0.
- On an advance (hold=0), the entries shift: T[s] <= T[s-1] for s≥1. T[DEPTH] retires.
- T[0] loads according to the highest-priority condition that applies:
  - flush: loads a bubble.
  - ld_stall: loads a bubble.
  - otherwise: loads {id_valid&id_we, id_dst_addr, id_is_load}.
- On flush, T[1] additionally loads a bubble, because the squashed EX instruction must not forward.
- Match: source k matches T[i] if id_src_used[k]=1, T[i] is live, and T[i].dst == src_k.
- ld_stall = id_valid & !flush & (some source matches T[0] with T[0].ld=1).
- Select, evaluated at ID for source k:
  - Consider only matches in T[0..DEPTH-1], because these entries sit at stages 1..DEPTH next cycle.
  - The smallest matching i wins (youngest producer). The select is sel=i+1.
  - ld flag = 1 iff i=0 and T[0].ld. This case only arises alongside ld_stall, so it never registers.
  - No match gives sel=0, ld=0.
- Register update on advance:
  - If flush or ld_stall or !id_valid: ex_fwd_sel <= 0 and ex_fwd_ld <= 0 (EX receives a bubble).
  - Otherwise ex_fwd_sel/ex_fwd_ld <= the decoded values. ex_fwd_ld[k] is registered as 1 when sel=1 and the producer, now in MEM, is a load.
- Correction to the ld flag above: a load at T[0] always stalls. ex_fwd_ld=1 therefore occurs only after the stall, and it is decoded from T[0] on the cycle the producer leaves EX.
- Priority: hold > flush > ld_stall > normal.
- Counter: increments when ld_stall & !hold & stall_cnt != all-ones. It saturates at 2^CNT_W-1. cnt_clr has priority over the increment and acts even under hold.

## Timing
- Reset (async, rst_n=0): all T entries are bubbles, ex_fwd_sel=0, ex_fwd_ld=0, stall_cnt=0. ld_stall is 0 because no entry is live.
- ld_stall is valid in the same cycle as the ID inputs (zero latency). ex_fwd_sel/ex_fwd_ld have 1-cycle latency and are valid throughout the consumer's EX cycle.
- hold=1: T, ex_fwd_sel, ex_fwd_ld and stall_cnt (except cnt_clr) all retain their values. ld_stall still reflects the current inputs.
- Producers in WB on the consumer's ID cycle are not forwarded. The register file is write-before-read.
- Reset asserted mid-stall clears everything immediately. The first cycle after release has no stall.

## Test plan
- ALU distance 1: cycle n, ID writes r3 (id_we=1). Cycle n+1, ID has src0=r3, src1=r5. Required: ld_stall=0 at n+1; at n+2, sel[0]=1, ld[0]=0, sel[1]=0.
- ALU distance 2: r3 produced at n, bubble at n+1, consumer of r3 at n+2. Required: sel[0]=2 at n+3.
- Load-use: lw r4 at n, consumer src1=r4 at n+1.
  - ld_stall=1 at n+1; sel=0 at n+2.
  - Consumer re-presented at n+2 gives ld_stall=0.
  - At n+3: sel[1]=1, ld[1]=1; stall_cnt=1.
- Youngest wins: r2 written at n and again at n+1, consumer at n+2. Required: sel=1. Also, r0 as destination or src_used=0 gives sel=0 and no stall.
- Flush and hold:
  - Producer r6 at n, flush at n+1 with a consumer of r6. Required: sel=0 at n+2, and r6 is not forwarded afterwards.
  - hold=1 for 3 cycles mid-sequence. Required: outputs unchanged.
- Counter: 2^CNT_W+2 stall cycles leaves stall_cnt saturated at all-ones. cnt_clr under hold gives 0 next cycle.
